// File: rtl/mini_cpu_pkg.sv
// Shared mini-cpu definitions: fetch FSM states, the reset NOP and the
// RV32I opcode/funct encodings also used by the decode/control block.
package mini_cpu_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// hands instructions to decode, dropping anything fetched down a wrong path.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mini_cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  import mini_cpu_pkg::*;

  fetch_state_t r_state, w_nextState;
  logic [31:0]  r_pc, w_nextPc;
  logic [31:0]  r_reqAddr, w_nextReqAddr;
  logic [31:0]  r_instr, w_nextInstr;
  logic [31:0]  r_instrPc, w_nextInstrPc;
  logic         r_instrValid, w_nextValid;
  logic [31:0]  w_target;

  assign w_target    = redirect_pc & ~32'h0000_0003;
  assign imem_addr   = r_reqAddr;
  assign instr       = r_instr;
  assign instr_pc    = r_instrPc;
  assign instr_valid = r_instrValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= START;
      r_pc         <= RESET_PC;
      r_reqAddr    <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_instrPc    <= RESET_PC;
      r_instrValid <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_reqAddr    <= w_nextReqAddr;
      r_instr      <= w_nextInstr;
      r_instrPc    <= w_nextInstrPc;
      r_instrValid <= w_nextValid;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = r_pc;
    w_nextReqAddr = r_reqAddr;
    w_nextInstr   = r_instr;
    w_nextInstrPc = r_instrPc;
    w_nextValid   = r_instrValid;
    imem_req      = 1'b0;

    unique case (r_state)
      START: begin
        w_nextReqAddr = r_pc;
        w_nextState   = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !redirect) begin
          w_nextInstr   = imem_rdata;
          w_nextInstrPc = r_reqAddr;
          w_nextValid   = 1'b1;
          w_nextPc      = r_reqAddr + 32'd4;
          w_nextState   = HOLD;
        end else if (imem_ack && redirect) begin
          w_nextPc      = w_target;
          w_nextReqAddr = w_target;
        end else if (redirect) begin
          w_nextPc    = w_target;
          w_nextState = DRAIN;
        end
      end

      // The request in flight is wrong-path; keep it stable until it retires.
      DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_nextPc = w_target;
        end
        if (imem_ack) begin
          w_nextReqAddr = redirect ? w_target : r_pc;
          w_nextState   = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          w_nextValid   = 1'b0;
          w_nextPc      = w_target;
          w_nextReqAddr = w_target;
          w_nextState   = FETCH;
        end else if (instr_ready) begin
          w_nextValid   = 1'b0;
          w_nextReqAddr = r_pc;
          w_nextState   = FETCH;
        end
      end

      default: w_nextState = START;
    endcase
  end

endmodule
